// File: rtl/sc_timer_bank.sv
// Bank of independent interval timers sharing one clock, one reset and one terminal-value load port.
// Each channel counts up to its terminal value, then ticks and either restarts (periodic) or latches done (one-shot).
module sc_timer_bank #(
    parameter int TIMER_DATAWIDTH_BUS = 26,
    parameter int TIMER_CHANNELS      = 4,
    parameter int TIMER_SEL_BUS       = 2
) (
    input  logic                                      SC_TIMER_CLOCK_50,
    input  logic                                      SC_TIMER_RESET_InHigh,
    input  logic [TIMER_CHANNELS-1:0]                 SC_TIMER_enable_InHigh,
    input  logic [TIMER_CHANNELS-1:0]                 SC_TIMER_clear_InHigh,
    input  logic [TIMER_CHANNELS-1:0]                 SC_TIMER_mode_In,
    input  logic                                      SC_TIMER_load_InHigh,
    input  logic [TIMER_SEL_BUS-1:0]                  SC_TIMER_loadSel_In,
    input  logic [TIMER_DATAWIDTH_BUS-1:0]            SC_TIMER_loadData_In,
    output logic [TIMER_CHANNELS-1:0]                 SC_TIMER_tick_OutHigh,
    output logic [TIMER_CHANNELS-1:0]                 SC_TIMER_done_OutHigh,
    output logic [TIMER_CHANNELS*TIMER_DATAWIDTH_BUS-1:0] SC_TIMER_count_Out
);

    localparam logic [TIMER_DATAWIDTH_BUS-1:0] ONE = 1;

    genvar gi;
    generate
        for (gi = 0; gi < TIMER_CHANNELS; gi++) begin : g_ch
            logic [TIMER_DATAWIDTH_BUS-1:0] count_reg;
            logic [TIMER_DATAWIDTH_BUS-1:0] term_reg;
            logic                           tick_reg;
            logic                           done_reg;
            logic                           load_hit;

            // Select values at or above TIMER_CHANNELS never match any channel, so they are ignored.
            assign load_hit = SC_TIMER_load_InHigh &&
                              (SC_TIMER_loadSel_In == TIMER_SEL_BUS'(gi));

            always_ff @(posedge SC_TIMER_CLOCK_50 or posedge SC_TIMER_RESET_InHigh) begin
                if (SC_TIMER_RESET_InHigh) begin
                    count_reg <= '0;
                    term_reg  <= '1;
                    tick_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end else begin
                    // The terminal test below sees the pre-edge term_reg, so a load takes effect next edge.
                    if (load_hit) begin
                        term_reg <= SC_TIMER_loadData_In;
                    end

                    if (SC_TIMER_clear_InHigh[gi]) begin
                        count_reg <= '0;
                        tick_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                    end else if (!SC_TIMER_enable_InHigh[gi] || done_reg) begin
                        tick_reg  <= 1'b0;
                    end else if (count_reg >= term_reg) begin
                        // Unsigned >= so a lowered terminal ends the run instead of wrapping.
                        tick_reg <= 1'b1;
                        if (SC_TIMER_mode_In[gi]) begin
                            done_reg <= 1'b1;
                        end else begin
                            count_reg <= '0;
                        end
                    end else begin
                        count_reg <= count_reg + ONE;
                        tick_reg  <= 1'b0;
                    end
                end
            end

            assign SC_TIMER_tick_OutHigh[gi] = tick_reg;
            assign SC_TIMER_done_OutHigh[gi] = done_reg;
            assign SC_TIMER_count_Out[gi*TIMER_DATAWIDTH_BUS +: TIMER_DATAWIDTH_BUS] = count_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sc_timer_bank.sv
// Self-checking bench for sc_timer_bank: vector table, directed corner sequences and randomized
// traffic, all compared against a behavioural channel model.
module tb_sc_timer_bank;

    localparam int W  = 4;
    localparam int CH = 4;
    localparam int SB = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     en, clr, mode;
    logic              ld;
    logic [SB-1:0]     sel;
    logic [W-1:0]      data;
    logic [CH-1:0]     tick, done;
    logic [CH*W-1:0]   cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural reference state.
    int m_c[CH];
    int m_t[CH];
    bit m_tick[CH];
    bit m_done[CH];

    sc_timer_bank #(
        .TIMER_DATAWIDTH_BUS(W),
        .TIMER_CHANNELS(CH),
        .TIMER_SEL_BUS(SB)
    ) dut (
        .SC_TIMER_CLOCK_50(clk),
        .SC_TIMER_RESET_InHigh(rst),
        .SC_TIMER_enable_InHigh(en),
        .SC_TIMER_clear_InHigh(clr),
        .SC_TIMER_mode_In(mode),
        .SC_TIMER_load_InHigh(ld),
        .SC_TIMER_loadSel_In(sel),
        .SC_TIMER_loadData_In(data),
        .SC_TIMER_tick_OutHigh(tick),
        .SC_TIMER_done_OutHigh(done),
        .SC_TIMER_count_Out(cnt)
    );

    always #5 clk = ~clk;

    function automatic int get_cnt(input int i);
        return int'(cnt[i*W +: W]);
    endfunction

    task automatic cmp(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_c[i] = 0;
            m_t[i] = (1 << W) - 1;
            m_tick[i] = 1'b0;
            m_done[i] = 1'b0;
        end
    endtask

    // One clock edge of the channel rules, evaluated on the current inputs.
    task automatic model_step();
        int old_t[CH];
        for (int i = 0; i < CH; i++) old_t[i] = m_t[i];
        if (ld && int'(sel) < CH) m_t[int'(sel)] = int'(data);
        for (int i = 0; i < CH; i++) begin
            if (clr[i]) begin
                m_c[i] = 0; m_done[i] = 1'b0; m_tick[i] = 1'b0;
            end else if (!en[i] || m_done[i]) begin
                m_tick[i] = 1'b0;
            end else if (m_c[i] >= old_t[i]) begin
                m_tick[i] = 1'b1;
                if (mode[i]) m_done[i] = 1'b1;
                else         m_c[i] = 0;
            end else begin
                m_c[i] = m_c[i] + 1;
                m_tick[i] = 1'b0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < CH; i++) begin
            cmp($sformatf("%s count ch%0d", tag, i), get_cnt(i), m_c[i]);
            cmp($sformatf("%s tick ch%0d", tag, i), int'(tick[i]), int'(m_tick[i]));
            cmp($sformatf("%s done ch%0d", tag, i), int'(done[i]), int'(m_done[i]));
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic idle_inputs();
        en = '0; clr = '0; ld = 1'b0; sel = '0; data = '0;
    endtask

    typedef struct {
        logic [CH-1:0] en, clr, mode;
        logic          ld;
        logic [SB-1:0] sel;
        logic [W-1:0]  data;
        logic [CH-1:0] e_tick, e_done;
        logic [W-1:0]  e_c0, e_c1;
    } vec_t;

    vec_t tbl[28];

    initial begin
        int first;
        int n0;
        // en, clr, mode, ld, sel, data, tick, done, c0, c1
        tbl[0]  = '{4'b0000, 4'b0000, 4'b0010, 1'b1, 3'd0, 4'd3, 4'b0000, 4'b0000, 4'd0, 4'd0};
        tbl[1]  = '{4'b0000, 4'b0000, 4'b0010, 1'b1, 3'd1, 4'd2, 4'b0000, 4'b0000, 4'd0, 4'd0};
        tbl[2]  = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0000, 4'd1, 4'd1};
        tbl[3]  = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0000, 4'd2, 4'd2};
        tbl[4]  = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0010, 4'b0010, 4'd3, 4'd2};
        tbl[5]  = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0001, 4'b0010, 4'd0, 4'd2};
        tbl[6]  = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0010, 4'd1, 4'd2};
        tbl[7]  = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0010, 4'd2, 4'd2};
        tbl[8]  = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0010, 4'd3, 4'd2};
        tbl[9]  = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0001, 4'b0010, 4'd0, 4'd2};
        tbl[10] = '{4'b0011, 4'b0010, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0000, 4'd1, 4'd0};
        tbl[11] = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0000, 4'd2, 4'd1};
        tbl[12] = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0000, 4'd3, 4'd2};
        tbl[13] = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0011, 4'b0010, 4'd0, 4'd2};
        tbl[14] = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0010, 4'd1, 4'd2};
        tbl[15] = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0010, 4'd2, 4'd2};
        tbl[16] = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0010, 4'd3, 4'd2};
        tbl[17] = '{4'b0001, 4'b0000, 4'b0010, 1'b1, 3'd0, 4'd5, 4'b0001, 4'b0010, 4'd0, 4'd2};
        tbl[18] = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0010, 4'd1, 4'd2};
        tbl[19] = '{4'b0001, 4'b0000, 4'b0010, 1'b1, 3'd4, 4'd0, 4'b0000, 4'b0010, 4'd2, 4'd2};
        tbl[20] = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0010, 4'd3, 4'd2};
        tbl[21] = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0010, 4'd4, 4'd2};
        tbl[22] = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0010, 4'd5, 4'd2};
        tbl[23] = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0001, 4'b0010, 4'd0, 4'd2};
        tbl[24] = '{4'b0001, 4'b0001, 4'b0010, 1'b1, 3'd0, 4'd2, 4'b0000, 4'b0010, 4'd0, 4'd2};
        tbl[25] = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0010, 4'd1, 4'd2};
        tbl[26] = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0000, 4'b0010, 4'd2, 4'd2};
        tbl[27] = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 3'd0, 4'd0, 4'b0001, 4'b0010, 4'd0, 4'd2};

        // Reset state
        idle_inputs();
        mode = '0;
        rst = 1'b1;
        model_reset();
        #12;
        check_model("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Vector table: periodic ch0, one-shot ch1, load timing, ignored select, clear+load
        for (int r = 0; r < 28; r++) begin
            en = tbl[r].en; clr = tbl[r].clr; mode = tbl[r].mode;
            ld = tbl[r].ld; sel = tbl[r].sel; data = tbl[r].data;
            step($sformatf("row%0d", r));
            cmp($sformatf("row%0d tick", r), int'(tick), int'(tbl[r].e_tick));
            cmp($sformatf("row%0d done", r), int'(done), int'(tbl[r].e_done));
            cmp($sformatf("row%0d c0", r), get_cnt(0), int'(tbl[r].e_c0));
            cmp($sformatf("row%0d c1", r), get_cnt(1), int'(tbl[r].e_c1));
            $display("row %0d: tick=%b done=%b c0=%0d c1=%0d", r, tick, done, get_cnt(0), get_cnt(1));
        end

        // T=0 periodic on ch2: tick on every enabled edge
        idle_inputs(); mode = '0;
        ld = 1'b1; sel = 3'd2; data = 4'd0; clr = 4'b0100;
        step("t0 load");
        idle_inputs(); en = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            step("t0 run");
            cmp($sformatf("t0 tick edge%0d", k), int'(tick[2]), 1);
            $display("t0 periodic edge %0d: tick2=%b c2=%0d", k, tick[2], get_cnt(2));
        end

        // Lowered terminal on ch2: T=10, run to C=7, then load T=4
        idle_inputs(); ld = 1'b1; sel = 3'd2; data = 4'd10; clr = 4'b0100;
        step("lower load10");
        idle_inputs(); en = 4'b0100;
        for (int k = 0; k < 7; k++) step("lower run");
        cmp("lower c2 at 7", get_cnt(2), 7);
        ld = 1'b1; sel = 3'd2; data = 4'd4;
        step("lower load4");
        cmp("lower c2 after load", get_cnt(2), 8);
        ld = 1'b0;
        step("lower term");
        cmp("lower tick", int'(tick[2]), 1);
        cmp("lower c2 wrap", get_cnt(2), 0);
        for (int k = 0; k < 5; k++) step("lower period");
        cmp("lower second tick", int'(tick[2]), 1);
        $display("lowered terminal: tick2=%b c2=%0d", tick[2], get_cnt(2));

        // Independence and pause: T=1,2,3,4, ch3 paused for 5 edges
        idle_inputs();
        for (int i = 0; i < CH; i++) begin
            ld = 1'b1; sel = SB'(i); data = W'(i + 1);
            step("indep load");
        end
        idle_inputs(); clr = '1;
        step("indep clear");
        idle_inputs();
        first = 0; n0 = 0;
        for (int e = 1; e <= 20; e++) begin
            en = (e >= 3 && e <= 7) ? 4'b0111 : 4'b1111;
            step("indep run");
            if (tick[3] && first == 0) first = e;
            if (tick[0]) n0++;
        end
        cmp("pause ch3 first tick edge", first, 10);
        cmp("ch0 ticks in 20 edges", n0, 10);
        $display("independence: ch3 first tick edge %0d, ch0 ticks %0d", first, n0);

        // Async reset mid-run: ch0 at C=5, ch1 done
        idle_inputs(); mode = 4'b0010;
        ld = 1'b1; sel = 3'd0; data = 4'd9; clr = 4'b0011;
        step("rst prep0");
        ld = 1'b1; sel = 3'd1; data = 4'd0; clr = '0;
        step("rst prep1");
        idle_inputs(); en = 4'b0011;
        for (int k = 0; k < 5; k++) step("rst run");
        cmp("pre-reset c0", get_cnt(0), 5);
        cmp("pre-reset done1", int'(done[1]), 1);
        #2;
        rst = 1'b1;
        #1;
        cmp("async reset count", int'(cnt), 0);
        cmp("async reset tick", int'(tick), 0);
        cmp("async reset done", int'(done), 0);
        $display("async reset: cnt=%0h tick=%b done=%b", cnt, tick, done);
        model_reset();
        @(posedge clk); #1;
        check_model("reset hold");
        rst = 1'b0;

        // Terminal readback after reset: first tick at edge 2^W
        idle_inputs(); mode = '0; en = 4'b0001;
        first = 0;
        for (int e = 1; e <= 40 && first == 0; e++) begin
            step("post-reset run");
            if (tick[0]) first = e;
        end
        cmp("post-reset first tick edge", first, 1 << W);
        $display("post-reset: first tick edge %0d", first);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            en   = CH'($urandom);
            clr  = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) mode = CH'($urandom);
            ld   = ($urandom_range(0, 3) == 0);
            sel  = SB'($urandom_range(0, 7));
            data = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 4)) : W'($urandom);
            step($sformatf("rand%0d", k));
            if (k % 50 == 0)
                $display("rand %0d: tick=%b done=%b cnt=%0h", k, tick, done, cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
